// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;

  localparam int DEFAULT_LATENCY = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to whoever
// did not own the memory last.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       req_if,
  input  logic       req_d,
  input  owner_t     last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req_if && req_d) begin
      if (last_owner == OWN_IF) grant[GNT_D] = 1'b1;
      else                      grant[GNT_IF] = 1'b1;
    end else if (req_d) begin
      grant[GNT_D] = 1'b1;
    end else if (req_if) begin
      grant[GNT_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// the load/store path, one latched request at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  owner_t            owner_reg, owner_next;
  owner_t            last_owner_reg, last_owner_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              wr_reg, wr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;

  logic [1:0] grant;
  logic       access;
  logic       last_cycle;

  arb_rr2 u_arb (
    .req_if     (if_req),
    .req_d      (d_req),
    .last_owner (last_owner_reg),
    .grant      (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      owner_reg      <= OWN_IF;
      last_owner_reg <= OWN_IF;
      addr_reg       <= '0;
      wr_reg         <= 1'b0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      addr_reg       <= addr_next;
      wr_reg         <= wr_next;
      wdata_reg      <= wdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    addr_next       = addr_reg;
    wr_next         = wr_reg;
    wdata_next      = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant[GNT_D]) begin
          state_next = ST_ACCESS;
          cnt_next   = '0;
          owner_next = OWN_D;
          addr_next  = d_addr;
          wr_next    = d_wr;
          wdata_next = d_wr ? d_wdata : '0;
        end else if (grant[GNT_IF]) begin
          state_next = ST_ACCESS;
          cnt_next   = '0;
          owner_next = OWN_IF;
          addr_next  = if_addr;
          wr_next    = 1'b0;
          wdata_next = '0;
        end
      end
      ST_ACCESS: begin
        if (cnt_reg == CNT_LAST) begin
          // Always drop back to IDLE so the requester can retire its request.
          state_next      = ST_IDLE;
          cnt_next        = '0;
          last_owner_next = owner_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign access     = (state_reg == ST_ACCESS);
  assign last_cycle = access && (cnt_reg == CNT_LAST);
  assign busy       = (state_reg != ST_IDLE);

  assign mem_enable  = access;
  assign mem_wr      = access && wr_reg;
  assign mem_addr    = access ? addr_reg : '0;
  assign mem_data_in = (access && wr_reg) ? wdata_reg : '0;

  assign if_done  = last_cycle && (owner_reg == OWN_IF);
  assign d_done   = last_cycle && (owner_reg == OWN_D);
  assign if_rdata = if_done ? mem_data_out : '0;
  assign d_rdata  = (d_done && !wr_reg) ? mem_data_out : '0;

endmodule
